// File: rtl/conv2d_seq_if.sv
// Interface bundle for conv2d_seq: start request, feature map, weights,
// bias, result map and the busy/done status. The master side (a host)
// drives operands and start; the slave side (the convolution engine)
// returns the result map and status.
interface conv2d_seq_if #(
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1,
  parameter int IN_HEIGHT    = 8,
  parameter int IN_WIDTH     = 8,
  parameter int DATA_WIDTH   = 8
);
  localparam int OUT_HEIGHT = (IN_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;

  logic                         start;
  logic signed [DATA_WIDTH-1:0] data_in  [IN_HEIGHT][IN_WIDTH][IN_CHANNELS];
  logic signed [DATA_WIDTH-1:0] weights  [OUT_CHANNELS][IN_CHANNELS][KERNEL_SIZE][KERNEL_SIZE];
  logic signed [DATA_WIDTH-1:0] bias     [OUT_CHANNELS];
  logic signed [DATA_WIDTH-1:0] data_out [OUT_HEIGHT][OUT_WIDTH][OUT_CHANNELS];
  logic                         busy;
  logic                         done;

  modport master (output start, data_in, weights, bias, input data_out, busy, done);
  modport slave  (input start, data_in, weights, bias, output data_out, busy, done);
endinterface

// File: rtl/conv2d_seq.sv
// Sequential 2D convolution: one multiply-accumulate per clock over every
// kernel tap (padded taps included, contributing zero), then one STORE
// cycle per output that applies bias, rounding, shift, activation and
// saturation. Loop order: oc, oy, ox (outputs) then ic, ky, kx (taps).
module conv2d_seq #(
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1,
  parameter int IN_HEIGHT    = 8,
  parameter int IN_WIDTH     = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int FRAC_BITS    = 4,
  parameter int HAS_BIAS     = 0,
  parameter int ACT_MODE     = 0,
  parameter int ROUND        = 1
) (
  input logic         clk,
  input logic         rst,
  conv2d_seq_if.slave bus
);
  localparam int OUT_HEIGHT = (IN_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int TAPS       = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
  localparam int DW         = DATA_WIDTH;
  localparam int PW         = 2 * DW;
  localparam int ACC_W      = PW + $clog2(TAPS) + 2;

  localparam int OCW = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int ICW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int OYW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int OXW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int IYW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int IXW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  localparam longint SAT_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam longint SAT_MIN = -(64'sd1 <<< (DW - 1));
  localparam longint R6_RAW  = 64'sd6 <<< FRAC_BITS;
  localparam longint R6_LIM  = (R6_RAW < SAT_MAX) ? R6_RAW : SAT_MAX;

  localparam logic signed [ACC_W-1:0] ZERO_A    = {ACC_W{1'b0}};
  localparam logic signed [ACC_W-1:0] SAT_MAX_A = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_MIN_A = ACC_W'(SAT_MIN);
  localparam logic signed [ACC_W-1:0] R6_A      = ACC_W'(R6_LIM);
  // Half-LSB of the post-shift result; zero when truncating or with no fraction
  localparam logic signed [ACC_W-1:0] RND_A     = (ROUND != 0 && FRAC_BITS > 0) ?
                                                  ACC_W'(64'sd1 <<< (FRAC_BITS - 1)) : {ACC_W{1'b0}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_STORE = 2'd2, S_DONE = 2'd3} state_t;

  state_t                   r_state, w_next;
  logic [OCW-1:0]           r_oc;
  logic [OYW-1:0]           r_oy;
  logic [OXW-1:0]           r_ox;
  logic [ICW-1:0]           r_ic;
  logic [KW-1:0]            r_ky, r_kx;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_busy, r_done;
  logic signed [DW-1:0]     r_data_out [OUT_HEIGHT][OUT_WIDTH][OUT_CHANNELS];

  logic                     w_last_tap, w_last_out, w_in;
  int                       w_iy, w_ix;
  logic [IYW-1:0]           w_iy_idx;
  logic [IXW-1:0]           w_ix_idx;
  logic signed [DW-1:0]     w_pix, w_wt, w_bias, w_res;
  logic signed [PW-1:0]     w_pix_x, w_wt_x, w_prod;
  logic signed [ACC_W-1:0]  w_prod_x, w_bias_x, w_sum, w_shift, w_act, w_sat;

  // Loop-end flags for the tap nest and the output nest
  always_comb begin
    w_last_tap = (r_kx == KW'(KERNEL_SIZE - 1)) && (r_ky == KW'(KERNEL_SIZE - 1)) &&
                 (r_ic == ICW'(IN_CHANNELS - 1));
    w_last_out = (r_ox == OXW'(OUT_WIDTH - 1)) && (r_oy == OYW'(OUT_HEIGHT - 1)) &&
                 (r_oc == OCW'(OUT_CHANNELS - 1));
  end

  // Next-state logic of the sequencer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_MAC;   else w_next = S_IDLE;
      S_MAC:   if (w_last_tap) w_next = S_STORE; else w_next = S_MAC;
      S_STORE: if (w_last_out) w_next = S_DONE;  else w_next = S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus registered busy/done status derived from next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_MAC) || (w_next == S_STORE);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Tap address generation and product; padded taps read as zero
  always_comb begin
    w_iy     = int'(r_oy) * STRIDE + int'(r_ky) - PADDING;
    w_ix     = int'(r_ox) * STRIDE + int'(r_kx) - PADDING;
    w_in     = (w_iy >= 0) && (w_iy < IN_HEIGHT) && (w_ix >= 0) && (w_ix < IN_WIDTH);
    w_iy_idx = w_in ? w_iy[IYW-1:0] : {IYW{1'b0}};
    w_ix_idx = w_in ? w_ix[IXW-1:0] : {IXW{1'b0}};
    w_pix    = w_in ? bus.data_in[w_iy_idx][w_ix_idx][r_ic] : {DW{1'b0}};
    w_wt     = bus.weights[r_oc][r_ic][r_ky][r_kx];
    w_pix_x  = {{DW{w_pix[DW-1]}}, w_pix};
    w_wt_x   = {{DW{w_wt[DW-1]}}, w_wt};
    w_prod   = w_pix_x * w_wt_x;
    w_prod_x = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  end

  // Output post-processing: bias, rounding, shift, activation, saturation
  always_comb begin
    w_bias = bus.bias[r_oc];
    if (HAS_BIAS != 0) begin
      w_bias_x = $signed({{(ACC_W-DW){w_bias[DW-1]}}, w_bias}) <<< FRAC_BITS;
    end else begin
      w_bias_x = ZERO_A;
    end
    w_sum   = r_acc + w_bias_x + RND_A;
    w_shift = w_sum >>> FRAC_BITS;
    if (ACT_MODE == 32'sd1) begin
      if (w_shift < ZERO_A) w_act = ZERO_A; else w_act = w_shift;
    end else if (ACT_MODE == 32'sd2) begin
      if (w_shift < ZERO_A)    w_act = ZERO_A;
      else if (w_shift > R6_A) w_act = R6_A;
      else                     w_act = w_shift;
    end else begin
      w_act = w_shift;
    end
    if (w_act > SAT_MAX_A)      w_sat = SAT_MAX_A;
    else if (w_act < SAT_MIN_A) w_sat = SAT_MIN_A;
    else                        w_sat = w_act;
    w_res = w_sat[DW-1:0];
  end

  // Datapath: accumulator, loop counters and the result map
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= ZERO_A;
      r_oc <= {OCW{1'b0}}; r_oy <= {OYW{1'b0}}; r_ox <= {OXW{1'b0}};
      r_ic <= {ICW{1'b0}}; r_ky <= {KW{1'b0}};  r_kx <= {KW{1'b0}};
      for (int y = 0; y < OUT_HEIGHT; y++)
        for (int x = 0; x < OUT_WIDTH; x++)
          for (int c = 0; c < OUT_CHANNELS; c++)
            r_data_out[y][x][c] <= {DW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc <= ZERO_A;
            r_oc <= {OCW{1'b0}}; r_oy <= {OYW{1'b0}}; r_ox <= {OXW{1'b0}};
            r_ic <= {ICW{1'b0}}; r_ky <= {KW{1'b0}};  r_kx <= {KW{1'b0}};
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_x;
          if (r_kx == KW'(KERNEL_SIZE - 1)) begin
            r_kx <= {KW{1'b0}};
            if (r_ky == KW'(KERNEL_SIZE - 1)) begin
              r_ky <= {KW{1'b0}};
              if (r_ic == ICW'(IN_CHANNELS - 1)) r_ic <= {ICW{1'b0}};
              else                               r_ic <= r_ic + 1'b1;
            end else begin
              r_ky <= r_ky + 1'b1;
            end
          end else begin
            r_kx <= r_kx + 1'b1;
          end
        end
        S_STORE: begin
          r_data_out[r_oy][r_ox][r_oc] <= w_res;
          r_acc <= ZERO_A;
          if (r_ox == OXW'(OUT_WIDTH - 1)) begin
            r_ox <= {OXW{1'b0}};
            if (r_oy == OYW'(OUT_HEIGHT - 1)) begin
              r_oy <= {OYW{1'b0}};
              if (r_oc == OCW'(OUT_CHANNELS - 1)) r_oc <= {OCW{1'b0}};
              else                                r_oc <= r_oc + 1'b1;
            end else begin
              r_oy <= r_oy + 1'b1;
            end
          end else begin
            r_ox <= r_ox + 1'b1;
          end
        end
        S_DONE: begin
          r_acc <= ZERO_A;
        end
        default: begin
          r_acc <= ZERO_A;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;

  for (genvar gy = 0; gy < OUT_HEIGHT; gy++) begin : g_oy
    for (genvar gx = 0; gx < OUT_WIDTH; gx++) begin : g_ox
      for (genvar gc = 0; gc < OUT_CHANNELS; gc++) begin : g_oc
        assign bus.data_out[gy][gx][gc] = r_data_out[gy][gx][gc];
      end
    end
  end
endmodule

// File: tb/tb_conv2d_seq.sv
// Scoreboard bench for conv2d_seq. Six instances cover the parameter
// corners: 4x4 K3 S1 P1 with ACT none/ReLU/ReLU6, 1x1 kernel with bias
// and ROUND=1/0, and 4x4 K3 S2 P1. Stimulus pushes hand-computed result
// maps and latencies into per-instance queues; monitors pop on done.
module tb_conv2d_seq;
  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  int   exp_lat [6][$];
  int   exp_val [6][$];
  int   t_start [6];
  int   n_done  [6];
  int   act_a[16], act_b[16], act_c[16], act_d[16], act_e[16], act_f[16];

  localparam int EXP_POS[16] = '{64, 96, 96, 64, 96, 127, 127, 96, 96, 127, 127, 96, 64, 96, 96, 64};
  localparam int EXP_NEG[16] = '{-64, -96, -96, -64, -96, -128, -128, -96,
                                 -96, -128, -128, -96, -64, -96, -96, -64};
  localparam int EXP_R6[16]  = '{64, 96, 96, 64, 96, 96, 96, 96, 96, 96, 96, 96, 64, 96, 96, 64};
  localparam int EXP_ZERO[16] = '{default: 0};
  localparam int EXP_S2[16]  = '{64, 96, 96, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int DATA_ID[16] = '{-128, -7, 0, 1, 5, 17, -33, 100, 127, -1, 64, -64, 2, -2, 33, 90};

  conv2d_seq_if #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .IN_HEIGHT(4), .IN_WIDTH(4)) if_a ();
  conv2d_seq_if #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .IN_HEIGHT(4), .IN_WIDTH(4)) if_b ();
  conv2d_seq_if #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .IN_HEIGHT(4), .IN_WIDTH(4)) if_c ();
  conv2d_seq_if #(.KERNEL_SIZE(1), .STRIDE(1), .PADDING(0), .IN_HEIGHT(1), .IN_WIDTH(1)) if_d ();
  conv2d_seq_if #(.KERNEL_SIZE(1), .STRIDE(1), .PADDING(0), .IN_HEIGHT(1), .IN_WIDTH(1)) if_e ();
  conv2d_seq_if #(.KERNEL_SIZE(3), .STRIDE(2), .PADDING(1), .IN_HEIGHT(4), .IN_WIDTH(4)) if_f ();

  conv2d_seq #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .IN_HEIGHT(4), .IN_WIDTH(4), .ACT_MODE(0))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  conv2d_seq #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .IN_HEIGHT(4), .IN_WIDTH(4), .ACT_MODE(1))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  conv2d_seq #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .IN_HEIGHT(4), .IN_WIDTH(4), .ACT_MODE(2))
    u_c (.clk(clk), .rst(rst), .bus(if_c));
  conv2d_seq #(.KERNEL_SIZE(1), .STRIDE(1), .PADDING(0), .IN_HEIGHT(1), .IN_WIDTH(1),
               .HAS_BIAS(1), .ROUND(1))
    u_d (.clk(clk), .rst(rst), .bus(if_d));
  conv2d_seq #(.KERNEL_SIZE(1), .STRIDE(1), .PADDING(0), .IN_HEIGHT(1), .IN_WIDTH(1),
               .HAS_BIAS(1), .ROUND(0))
    u_e (.clk(clk), .rst(rst), .bus(if_e));
  conv2d_seq #(.KERNEL_SIZE(3), .STRIDE(2), .PADDING(1), .IN_HEIGHT(4), .IN_WIDTH(4))
    u_f (.clk(clk), .rst(rst), .bus(if_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter, one per rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pop one expected response for instance id and compare it with the DUT
  task automatic sb_check(input int id, input int n, input int act[16]);
    int e;
    n_done[id]++;
    if (exp_lat[id].size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_done dut%0d: got a done pulse, expected none", id);
    end else begin
      e = exp_lat[id].pop_front();
      cmp($sformatf("latency_dut%0d", id), cyc - t_start[id], e);
      for (int i = 0; i < n; i++) begin
        e = exp_val[id].pop_front();
        cmp($sformatf("dout_dut%0d[%0d]", id, i), act[i], e);
      end
    end
  endtask

  // monitors: one per instance, sampled on the falling edge
  always @(negedge clk) if (if_a.done) begin
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) act_a[y*4+x] = int'(if_a.data_out[y][x][0]);
    sb_check(0, 16, act_a);
  end
  always @(negedge clk) if (if_b.done) begin
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) act_b[y*4+x] = int'(if_b.data_out[y][x][0]);
    sb_check(1, 16, act_b);
  end
  always @(negedge clk) if (if_c.done) begin
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) act_c[y*4+x] = int'(if_c.data_out[y][x][0]);
    sb_check(2, 16, act_c);
  end
  always @(negedge clk) if (if_d.done) begin
    act_d[0] = int'(if_d.data_out[0][0][0]);
    sb_check(3, 1, act_d);
  end
  always @(negedge clk) if (if_e.done) begin
    act_e[0] = int'(if_e.data_out[0][0][0]);
    sb_check(4, 1, act_e);
  end
  always @(negedge clk) if (if_f.done) begin
    for (int y = 0; y < 2; y++) for (int x = 0; x < 2; x++) act_f[y*2+x] = int'(if_f.data_out[y][x][0]);
    sb_check(5, 4, act_f);
  end

  task automatic set_start(input int id, input logic v);
    case (id)
      0: if_a.start = v;
      1: if_b.start = v;
      2: if_c.start = v;
      3: if_d.start = v;
      4: if_e.start = v;
      5: if_f.start = v;
      default: ;
    endcase
  endtask

  function automatic int get_busy(input int id);
    case (id)
      0: return int'(if_a.busy);
      1: return int'(if_b.busy);
      2: return int'(if_c.busy);
      3: return int'(if_d.busy);
      4: return int'(if_e.busy);
      default: return int'(if_f.busy);
    endcase
  endfunction

  function automatic int get_done(input int id);
    case (id)
      0: return int'(if_a.done);
      1: return int'(if_b.done);
      2: return int'(if_c.done);
      3: return int'(if_d.done);
      4: return int'(if_e.done);
      default: return int'(if_f.done);
    endcase
  endfunction

  // Uniform fill: every pixel d, every weight w, bias b
  task automatic fill(input int id, input int d, input int w, input int b);
    case (id)
      0: begin
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) if_a.data_in[y][x][0] = 8'(d);
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if_a.weights[0][0][i][j] = 8'(w);
        if_a.bias[0] = 8'(b);
      end
      1: begin
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) if_b.data_in[y][x][0] = 8'(d);
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if_b.weights[0][0][i][j] = 8'(w);
        if_b.bias[0] = 8'(b);
      end
      2: begin
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) if_c.data_in[y][x][0] = 8'(d);
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if_c.weights[0][0][i][j] = 8'(w);
        if_c.bias[0] = 8'(b);
      end
      3: begin
        if_d.data_in[0][0][0] = 8'(d); if_d.weights[0][0][0][0] = 8'(w); if_d.bias[0] = 8'(b);
      end
      4: begin
        if_e.data_in[0][0][0] = 8'(d); if_e.weights[0][0][0][0] = 8'(w); if_e.bias[0] = 8'(b);
      end
      default: begin
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) if_f.data_in[y][x][0] = 8'(d);
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if_f.weights[0][0][i][j] = 8'(w);
        if_f.bias[0] = 8'(b);
      end
    endcase
  endtask

  task automatic launch(input int id);
    @(negedge clk);
    set_start(id, 1'b1);
    t_start[id] = cyc + 1;
    @(negedge clk);
    set_start(id, 1'b0);
  endtask

  task automatic wait_done(input int id, input int target);
    int k;
    k = 0;
    while (n_done[id] < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    cmp($sformatf("done_seen_dut%0d", id), (n_done[id] >= target) ? 1 : 0, 1);
    @(negedge clk);
    cmp($sformatf("idle_after_done_dut%0d", id), get_busy(id) + get_done(id), 0);
  endtask

  task automatic run(input int id, input int vals[16], input int n, input int lat);
    int target;
    exp_lat[id].push_back(lat);
    for (int i = 0; i < n; i++) exp_val[id].push_back(vals[i]);
    target = n_done[id] + 1;
    launch(id);
    wait_done(id, target);
  endtask

  task automatic check_a_zero(input string name);
    int nz;
    nz = 0;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) if (if_a.data_out[y][x][0] != 8'sd0) nz++;
    cmp(name, nz, 0);
  endtask

  initial begin
    int v[16];
    int target;
    cyc = 0; n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 6; i++) begin n_done[i] = 0; t_start[i] = 0; set_start(i, 1'b0); fill(i, 0, 0, 0); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp("reset_busy", int'(if_a.busy), 0);
    cmp("reset_done", int'(if_a.done), 0);
    check_a_zero("reset_dout_nonzero");
    rst = 1'b1;
    @(negedge clk);

    // 3x3 all-16 map: corners 4 taps, edges 6, interior 9 saturates
    fill(0, 16, 16, 0);   run(0, EXP_POS, 16, 160);
    fill(0, 16, -16, 0);  run(0, EXP_NEG, 16, 160);
    // identity kernel: centre weight 1.0, output reproduces input
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) if_a.data_in[y][x][0] = 8'(DATA_ID[y*4+x]);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if_a.weights[0][0][i][j] = 8'sd0;
    if_a.weights[0][0][1][1] = 8'sd16;
    run(0, DATA_ID, 16, 160);

    fill(1, 16, -16, 0);  run(1, EXP_ZERO, 16, 160);
    fill(1, 16, 16, 0);   run(1, EXP_POS, 16, 160);
    fill(2, 16, 16, 0);   run(2, EXP_R6, 16, 160);

    // 1x1 kernel: product 8 -> 0.5 LSB; rounding, truncation, bias
    v = '{default: 0};
    v[0] = 1;   fill(3, 1, 8, 0);   run(3, v, 1, 2);
    v[0] = 17;  fill(3, 1, 8, 16);  run(3, v, 1, 2);
    v[0] = 0;   fill(3, -1, 8, 0);  run(3, v, 1, 2);
    v[0] = 0;   fill(4, 1, 8, 0);   run(4, v, 1, 2);
    v[0] = -1;  fill(4, -1, 8, 0);  run(4, v, 1, 2);

    fill(5, 16, 16, 0);   run(5, EXP_S2, 4, 40);

    // second start mid-run must be ignored
    fill(0, 16, 16, 0);
    exp_lat[0].push_back(160);
    for (int i = 0; i < 16; i++) exp_val[0].push_back(EXP_POS[i]);
    target = n_done[0] + 1;
    launch(0);
    repeat (30) @(negedge clk);
    cmp("midrun_busy", get_busy(0), 1);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    wait_done(0, target);
    repeat (200) @(negedge clk);
    cmp("single_done_count", n_done[0], target);

    // reset mid-run: abandon with no done, map cleared
    fill(0, 16, -16, 0);
    target = n_done[0];
    launch(0);
    repeat (50) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cmp("midreset_busy", get_busy(0), 0);
    cmp("midreset_done", get_done(0), 0);
    check_a_zero("midreset_dout_nonzero");
    repeat (200) @(negedge clk);
    cmp("midreset_no_done", n_done[0], target);
    run(0, EXP_NEG, 16, 160);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/conv2d_seq.md
CONV2D_SEQ -- requirements
Module: conv2d_seq

Interface
REQ-001 SHALL have parameter IN_CHANNELS, default 1, number of input channels.
REQ-002 SHALL have parameter OUT_CHANNELS, default 1, number of output channels.
REQ-003 SHALL have parameter KERNEL_SIZE, default 3, square kernel edge.
REQ-004 SHALL have parameter STRIDE, default 1, and PADDING, default 1, with zero padding.
REQ-005 SHALL have parameters IN_HEIGHT, default 8, and IN_WIDTH, default 8, input map size.
REQ-006 SHALL have parameters DATA_WIDTH, default 8, and FRAC_BITS, default 4: signed fixed point, also used for weights and bias.
REQ-007 SHALL have parameter HAS_BIAS, default 0: 1 adds a per-output-channel bias.
REQ-008 SHALL have parameter ACT_MODE, default 0: 0 none, 1 ReLU, 2 ReLU6.
REQ-009 SHALL have parameter ROUND, default 1: 1 rounds half-up before the shift, 0 truncates.
REQ-010 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-011 SHALL have port rst, input, 1, reset that is synchronous and active-low.
REQ-012 SHALL have port start, input, 1, a request to begin one full convolution.
REQ-013 SHALL have port data_in, input, DATA_WIDTH x [IN_HEIGHT][IN_WIDTH][IN_CHANNELS], the feature map.
REQ-014 SHALL have port weights, input, DATA_WIDTH x [OUT_CHANNELS][IN_CHANNELS][KERNEL_SIZE][KERNEL_SIZE].
REQ-015 SHALL have port bias, input, DATA_WIDTH x [OUT_CHANNELS]; it is ignored when HAS_BIAS=0.
REQ-016 SHALL have port data_out, output, DATA_WIDTH x [OUT_HEIGHT][OUT_WIDTH][OUT_CHANNELS], the result map.
REQ-017 SHALL have port busy, output, 1, high while a convolution is in progress.
REQ-018 SHALL have port done, output, 1, a one-cycle pulse when data_out is complete.
REQ-019 SHALL compute OUT_H/W = (IN_H/W + 2*PADDING - KERNEL_SIZE)/STRIDE + 1, and define TAPS = IN_CHANNELS*KERNEL_SIZE^2 and N_OUT = OUT_H*OUT_W*OUT_CHANNELS.

Function
REQ-020 SHALL implement FSM states IDLE, MAC, STORE and DONE; each step below is one clk edge.
REQ-021 SHALL, in IDLE with start=1, clear the accumulator and counters and enter MAC.
REQ-022 SHALL ignore start in any state other than IDLE.
REQ-023 SHALL, in MAC, perform one multiply-accumulate per cycle, ordered oc outer, then oy, ox, ic, ky, kx innermost.
REQ-024 SHALL spend a MAC cycle on every out-of-bounds (padded) tap and add zero for it, so timing does not depend on the data.
REQ-025 SHALL go from MAC to STORE after TAPS MAC cycles.
REQ-026 SHALL, in STORE, write data_out[oy][ox][oc], clear the accumulator, then enter MAC for the next output, or DONE after the last output.
REQ-027 SHALL, in DONE, assert done for exactly one cycle and then enter IDLE.
REQ-028 SHALL assert done exactly N_OUT*(TAPS+1) cycles after the edge that samples start.
REQ-029 SHALL hold busy high in MAC and STORE and low in IDLE and DONE.
REQ-030 SHALL use a full-precision product width of 2*DATA_WIDTH.
REQ-031 SHALL use an accumulator width of 2*DATA_WIDTH + clog2(TAPS) + 2, which never overflows.
REQ-032 SHALL, when HAS_BIAS=1, add bias[oc] <<< FRAC_BITS to the accumulator in STORE.
REQ-033 SHALL, in STORE, add 2^(FRAC_BITS-1) when ROUND=1 and FRAC_BITS>0, then arithmetic-shift right by FRAC_BITS.
REQ-034 SHALL apply the activation after the shift: ReLU clamps negatives to 0; ReLU6 clamps to [0, min(6<<FRAC_BITS, 2^(DATA_WIDTH-1)-1)].
REQ-035 SHALL finally saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-036 SHALL keep every data_out element unchanged until its own STORE cycle, so a re-run overwrites the elements in order.
REQ-037 SHALL produce undefined results if data_in, weights or bias change while busy=1; no error is flagged.

Reset
REQ-038 SHALL, when rst=0 at a clk edge in any state, enter IDLE and clear busy, done, the accumulator, the counters and all of data_out to 0.
REQ-039 SHALL abandon a reset taken mid-operation with no done pulse; a start after rst=1 runs the full N_OUT*(TAPS+1) cycles.

Verification
REQ-040 SHALL check: 4x4x1 map, K3 S1 P1, DW8 FB4, every data and weight 16 -> corners 64, edges 96, interior 127 (saturated), done 160 cycles after start.
REQ-041 SHALL check: the same setup with weights -16 and ACT_MODE=1 -> all outputs 0; with weights 16 and ACT_MODE=2 -> corners 64, edges 96, interior 96.
REQ-042 SHALL check: a 1x1 kernel, P0, data 1, weight 8 (product 8) -> output 1 when ROUND=1 and 0 when ROUND=0; with HAS_BIAS=1 and bias 16 -> output 17 when ROUND=1.
REQ-043 SHALL check: a 4x4 map, K3 S2 P1 -> 2x2 output; element [0][0] with all-16 data and weights equals 64; done 40 cycles after start.
REQ-044 SHALL check: start pulsed again mid-run -> no restart and a single done; rst=0 mid-run -> data_out all 0, busy 0, no done, and a clean later run.
